// File: rtl/bram_port_initiator_pkg.sv
// Shared constants for the BRAM port initiator: response FIFO sizing and grant encoding.
// Pure declarations, no logic.
package bram_port_initiator_pkg;

    localparam int RESP_FIFO_DEPTH = 2;
    localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int RESP_PTR_W      = $clog2(RESP_FIFO_DEPTH);

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/bram_resp_fifo.sv
// 2-entry read response FIFO with registered head output; push visible one cycle later.
// Caller guarantees no push when full and no pop when empty; illegal requests are ignored.
module bram_resp_fifo
    import bram_port_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [RESP_CNT_W-1:0] count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] buf_q [RESP_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [RESP_FIFO_DEPTH];
    logic [RESP_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RESP_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [RESP_CNT_W-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != RESP_CNT_W'(RESP_FIFO_DEPTH)) || pop_ok);

        if (push_ok) begin
            buf_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + RESP_CNT_W'(1);
            2'b01:   count_d = count_q - RESP_CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Head is precomputed from next state so the output comes straight from a flop.
        head_d = buf_d[rd_ptr_d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/bram_port_initiator.sv
// Arbitrates write and read requests onto one BRAM port; memory driven in the accept cycle,
// read data returned 2 cycles after accept; reads stall when response buffering is exhausted, writes never do.
module bram_port_initiator
    import bram_port_initiator_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_resp_valid,
    input  logic                     rd_resp_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_ce,
    output logic [DATA_WIDTH-1:0]    mem_d,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_q
);

    localparam int OCC_W = RESP_CNT_W + 1;

    grant_e                rr_q, rr_d;
    logic                  pend_q, pend_d;
    logic [RESP_CNT_W-1:0] fifo_cnt;
    logic [OCC_W-1:0]      occupancy;
    logic                  pop;
    logic                  rd_elig;
    logic                  rd_cand;
    logic                  wr_go;
    logic                  rd_go;

    assign rd_resp_valid = (fifo_cnt != '0);
    assign pop           = rd_resp_valid & rd_resp_ready;

    always_comb begin
        rr_d        = rr_q;
        pend_d      = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_address = '0;
        mem_d       = '0;

        // Count the read already in flight so a full FIFO can never be overrun.
        occupancy = OCC_W'(fifo_cnt) + OCC_W'(pend_q) - OCC_W'(pop);
        rd_elig   = (occupancy < OCC_W'(RESP_FIFO_DEPTH));
        rd_cand   = rd_req_valid & rd_elig;

        wr_go = wr_valid & (~rd_cand | (rr_q == GRANT_WR));
        rd_go = rd_cand & (~wr_valid | (rr_q == GRANT_RD));

        if (wr_go) begin
            mem_ce      = 1'b1;
            mem_we      = 1'b1;
            mem_address = wr_addr;
            mem_d       = wr_data;
            rr_d        = GRANT_RD;
        end else if (rd_go) begin
            mem_ce      = 1'b1;
            mem_address = rd_addr;
            pend_d      = 1'b1;
            rr_d        = GRANT_WR;
        end
    end

    assign wr_ready     = wr_go;
    assign rd_req_ready = rd_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q   <= GRANT_WR;
            pend_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            pend_q <= pend_d;
        end
    end

    bram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (pend_q),
        .push_data_i (mem_q),
        .pop_i       (pop),
        .count_o     (fifo_cnt),
        .head_o      (rd_data)
    );

endmodule

// File: tb/tb_bram_port_initiator.sv
// Bench for bram_port_initiator: directed scenarios plus random traffic, checked by a
// negedge monitor against a reference memory array and an expected-response queue.
module tb_bram_port_initiator;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [DW-1:0] rd_data;
    logic          rd_resp_valid;
    logic          rd_resp_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_ce;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] dev     [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pop_dat[$];
    int            pop_cyc[$];

    bram_port_initiator #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_addr       (rd_addr),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_data       (rd_data),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .mem_address   (mem_address),
        .mem_ce        (mem_ce),
        .mem_d         (mem_d),
        .mem_we        (mem_we),
        .mem_q         (mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return (32'(i) * 32'h0103_0507) ^ 32'h5A5A_0000;
    endfunction

    // Single-port memory device: 1-cycle read latency, q held when not reading.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) dev[i] <= init_val(i);
            mem_q <= '0;
        end else if (mem_ce) begin
            if (mem_we) dev[mem_address] <= mem_d;
            else        mem_q <= dev[mem_address];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: abstract arbitration rules, memory-port contents and in-order read data.
    initial begin : monitor
        bit last_rd;
        bit pop, wf, rf, elig;
        int occ;
        last_rd = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                last_rd = 1'b1;
                for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
            end else begin
                pop  = rd_resp_valid && rd_resp_ready;
                wf   = wr_valid && wr_ready;
                rf   = rd_req_valid && rd_req_ready;
                occ  = exp_q.size() - (pop ? 1 : 0);
                elig = (occ < 2);
                chk("single_access", 64'(wf && rf), 64'(0));
                if (!wr_valid) chk("wr_ready_idle", 64'(wr_ready), 64'(0));
                if (!rd_req_valid) chk("rd_ready_idle", 64'(rd_req_ready), 64'(0));
                if (rd_req_valid && !elig) chk("rd_ready_full", 64'(rd_req_ready), 64'(0));
                if (wr_valid && rd_req_valid && elig) begin
                    chk("rr_wr", 64'(wr_ready), 64'(last_rd));
                    chk("rr_rd", 64'(rd_req_ready), 64'(!last_rd));
                end else begin
                    if (wr_valid) chk("wr_ready", 64'(wr_ready), 64'(1));
                    if (rd_req_valid && elig) chk("rd_ready", 64'(rd_req_ready), 64'(1));
                end
                if (wf) begin
                    chk("wr_mem_ce", 64'(mem_ce), 64'(1));
                    chk("wr_mem_we", 64'(mem_we), 64'(1));
                    chk("wr_mem_addr", 64'(mem_address), 64'(wr_addr));
                    chk("wr_mem_d", 64'(mem_d), 64'(wr_data));
                end else if (rf) begin
                    chk("rd_mem_ce", 64'(mem_ce), 64'(1));
                    chk("rd_mem_we", 64'(mem_we), 64'(0));
                    chk("rd_mem_addr", 64'(mem_address), 64'(rd_addr));
                end else begin
                    chk("idle_mem_ce", 64'(mem_ce), 64'(0));
                    chk("idle_mem_we", 64'(mem_we), 64'(0));
                end
                if (pop) begin
                    chk("resp_has_request", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                        pop_dat.push_back(rd_data);
                        pop_cyc.push_back(cyc);
                    end
                end
                if (wf) begin
                    ref_mem[wr_addr] = wr_data;
                    last_rd = 1'b0;
                end
                if (rf) begin
                    exp_q.push_back(ref_mem[rd_addr]);
                    last_rd = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_valid = 1'b0;
        rd_req_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        wr_addr = a;
        wr_data = d;
        wr_valid = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (wr_ready) got = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        chk("wr_accept", 64'(got), 64'(1));
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit got;
        got = 1'b0;
        rd_addr = a;
        rd_req_valid = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rd_req_ready) got = 1'b1;
            step();
        end
        rd_req_valid = 1'b0;
        chk("rd_accept", 64'(got), 64'(1));
    endtask

    initial begin : stimulus
        int  acc;
        int  seen;
        bit  got;
        bit  wf, rf;

        // Reset state
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_resp_valid", 64'(rd_resp_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_mem_ce", 64'(mem_ce), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        step();
        reset = 1'b0;

        // Round trip with exact response latency
        rd_resp_ready = 1'b1;
        do_write(6'd5, 32'hDEAD_BEEF);
        do_read(6'd5);
        @(negedge clk);
        chk("rt_lat1_valid", 64'(rd_resp_valid), 64'(0));
        @(negedge clk);
        chk("rt_lat2_valid", 64'(rd_resp_valid), 64'(1));
        chk("rt_data", 64'(rd_data), 64'(32'hDEAD_BEEF));
        step();

        // Conflict right after reset: write, then read, then write again
        do_reset();
        wr_addr = 6'd3; wr_data = 32'h0000_00A1; wr_valid = 1'b1;
        rd_addr = 6'd7; rd_req_valid = 1'b1;
        @(negedge clk);
        chk("cf1_wr_ready", 64'(wr_ready), 64'(1));
        chk("cf1_rd_ready", 64'(rd_req_ready), 64'(0));
        step();
        wr_data = 32'h0000_00B2;
        @(negedge clk);
        chk("cf2_wr_ready", 64'(wr_ready), 64'(0));
        chk("cf2_rd_ready", 64'(rd_req_ready), 64'(1));
        step();
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("cf3_wr_ready", 64'(wr_ready), 64'(1));
        step();
        wr_valid = 1'b0;
        repeat (4) step();

        // Backpressure: only two reads fit while responses are held
        do_reset();
        pop_dat.delete();
        rd_resp_ready = 1'b0;
        acc = 0;
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            rd_req_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                @(negedge clk);
                if (rd_req_ready) got = 1'b1;
                step();
            end
            if (got) acc++;
        end
        @(negedge clk);
        chk("bp_rd_ready_low", 64'(rd_req_ready), 64'(0));
        chk("bp_accepted", 64'(acc), 64'(2));
        step();
        rd_req_valid = 1'b0;
        rd_resp_ready = 1'b1;
        do_read(6'd2);
        do_read(6'd3);
        repeat (6) step();
        chk("bp_resp_count", 64'(pop_dat.size()), 64'(4));
        for (int i = 0; i < 4 && i < pop_dat.size(); i++)
            chk("bp_order", 64'(pop_dat[i]), 64'(init_val(i)));

        // Streaming: one read per cycle with the response side always ready
        do_reset();
        pop_cyc.delete();
        rd_resp_ready = 1'b1;
        acc = 0;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i + 16);
            @(negedge clk);
            if (rd_req_ready) acc++;
            step();
        end
        rd_req_valid = 1'b0;
        repeat (6) step();
        chk("stream_accepts", 64'(acc), 64'(16));
        chk("stream_resps", 64'(pop_cyc.size()), 64'(16));
        if (pop_cyc.size() == 16)
            chk("stream_span", 64'(pop_cyc[15] - pop_cyc[0]), 64'(15));

        // Read-after-write to the same address on the next cycle
        do_reset();
        rd_resp_ready = 1'b1;
        do_write(6'd9, 32'h0000_0012);
        do_read(6'd9);
        got = 1'b0;
        for (int t = 0; t < 6 && !got; t++) begin
            @(negedge clk);
            if (rd_resp_valid) got = 1'b1;
        end
        chk("raw_resp_seen", 64'(got), 64'(1));
        chk("raw_data", 64'(rd_data), 64'(32'h0000_0012));
        step();

        // Reset with two responses buffered
        do_reset();
        rd_resp_ready = 1'b0;
        do_read(6'd1);
        do_read(6'd2);
        repeat (3) @(negedge clk);
        chk("mid_buffered", 64'(rd_resp_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(rd_resp_valid), 64'(0));
        chk("mid_rst_data", 64'(rd_data), 64'(0));
        step();
        step();
        reset = 1'b0;
        rd_resp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_resp_valid) seen++;
        end
        chk("mid_no_resp", 64'(seen), 64'(0));
        step();

        // Random mixed traffic with random response backpressure
        do_reset();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            wf = wr_valid && wr_ready;
            rf = rd_req_valid && rd_req_ready;
            step();
            if (!wr_valid || wf) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_addr  = AW'($urandom_range(0, 15));
                wr_data  = $urandom;
            end
            if (!rd_req_valid || rf) begin
                rd_req_valid = ($urandom_range(0, 1) == 0);
                rd_addr      = AW'($urandom_range(0, 15));
            end
            rd_resp_ready = ($urandom_range(0, 3) != 0);
        end
        wr_valid = 1'b0;
        rd_req_valid = 1'b0;
        rd_resp_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
